spi_frame_monitor: RTL
======================

SPI_FRAME_MONITOR -- requirements
Module: spi_frame_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per captured word (range 4..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of captured-word entries (power of two, 2..16).
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning 1 = first sampled bit lands in bit DATA_W-1 and 0 = it lands in bit 0.
REQ-004 clk  input  1  system clock; all logic on rising edge; SHALL run at least 4x sck frequency.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 cpol, cpha  input  1 each  SPI mode; latched at frame start.
REQ-007 sck, cs_n, mosi, miso  input  1 each  SPI pins, asynchronous to clk.
REQ-008 out_valid  output  1  FIFO head entry present.
REQ-009 out_ready  input  1  consumer accepts head entry.
REQ-010 out_mosi, out_miso  output  DATA_W each  head-entry data.
REQ-011 out_bits  output  $clog2(DATA_W+1)  valid bit count of head entry.
REQ-012 out_sof  output  1  head entry is the first word of its frame.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH+1)  occupied entries.
REQ-014 overflow  output  1  sticky dropped-word flag; clear_overflow  input  1  clears it.

Function
REQ-015 sck, cs_n, mosi and miso SHALL each pass through a 2-flop synchroniser; edge detection SHALL compare synchronised sck with a third registered copy.
REQ-016 FSM states SHALL be IDLE and ACTIVE; IDLE->ACTIVE on synchronised cs_n falling; ACTIVE->IDLE on synchronised cs_n rising.
REQ-017 On IDLE->ACTIVE the block SHALL latch cpol/cpha, clear the bit counter and shift registers, and set the sof marker. Changes to cpol/cpha during ACTIVE SHALL have no effect.
REQ-018 Sample edge SHALL be the leading edge (rising if cpol=0, falling if cpol=1) when cpha=0, and the trailing edge when cpha=1; mosi and miso SHALL be sampled together on it.
REQ-019 Each sample SHALL shift one bit into the mosi and miso shift registers in MSB_FIRST order and increment the bit counter.
REQ-020 On the DATA_W-th sample the word SHALL be pushed with out_bits=DATA_W and the current sof marker; the counter SHALL reset, the sof marker SHALL clear, and capture SHALL continue within the frame.
REQ-021 Latency: out_valid SHALL rise exactly 4 clk cycles after the clk edge at which the first synchroniser flop captures the completing sck edge, provided the FIFO was empty.
REQ-022 A sample edge detected in the same cycle as the synchronised cs_n rise SHALL be discarded.
REQ-023 An sck edge while IDLE SHALL be ignored.
REQ-024 Handshake: an entry SHALL pop on the cycle where out_valid and out_ready are both 1. out_valid SHALL NOT drop without a pop. Head data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 When out_valid=0, out_mosi, out_miso, out_bits and out_sof SHALL be 0.
REQ-026 Full FIFO with a push and no pop: the word SHALL be dropped, overflow SHALL set, and the stored contents SHALL be unchanged. Full FIFO with push and pop in the same cycle: both SHALL succeed and the level SHALL be unchanged.
REQ-027 If clear_overflow is asserted in the same cycle as a new overflow, the set SHALL win.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH, and fifo_level SHALL be exact (0..FIFO_DEPTH).

Reset
REQ-029 While rst=0: FSM=IDLE, FIFO empty, and all synchroniser, shift and counter registers zero. Synchroniser flops holding sck, cs_n and mosi/miso SHALL reset to cpol-independent 0, except cs_n flops, which SHALL reset to 1.
REQ-030 Reset outputs SHALL be out_valid=0, out_mosi=0, out_miso=0, out_bits=0, out_sof=0, fifo_level=0 and overflow=0.
REQ-031 Reset asserted mid-frame or mid-handshake SHALL discard all partial and stored data. After release, capture SHALL resume only at the next cs_n fall.

Configuration
REQ-032 Macro SPI_FRAME_MONITOR_PARTIAL_EN: when defined, a cs_n rise with 1..DATA_W-1 bits pending SHALL push that partial word. The pushed word SHALL be right-aligned if MSB_FIRST=1, low-aligned otherwise, with out_bits equal to the count and unfilled bits 0.
REQ-033 When the macro is undefined, partial words SHALL be silently discarded, and out_bits SHALL always be DATA_W for valid entries.

Verification
REQ-034 Mode 0, DATA_W=8, cs_n low, mosi 0xA5 / miso 0x3C, 8 clocks, cs_n high -> one entry: out_mosi=0xA5, out_miso=0x3C, out_bits=8, out_sof=1.
REQ-035 Mode 3, 16 clocks in one frame with mosi 0x12,0x34 -> two entries: 0x12 with sof=1, then 0x34 with sof=0.
REQ-036 FIFO_DEPTH=4, out_ready=0, 5 words sent -> fifo_level=4, overflow=1, the popped sequence equals the first 4 words, and clear_overflow then makes overflow=0.
REQ-037 Frame of 5 bits mosi 10110 -> with PARTIAL_EN: out_mosi=0x16, out_bits=5; without PARTIAL_EN: no entry and fifo_level=0.
REQ-038 rst pulsed low after 4 bits of a frame, followed by a full 8-bit frame 0x5A -> exactly one entry, 0x5A with sof=1.

Source files
------------

// File: rtl/spi_frame_monitor.sv
// Passive SPI bus monitor: captures mosi/miso words per cs_n frame into a small FIFO.
// Define SPI_FRAME_MONITOR_PARTIAL_EN to also push incomplete words at frame end.
module spi_frame_monitor #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpol,
    input  logic                            cpha,
    input  logic                            sck,
    input  logic                            cs_n,
    input  logic                            mosi,
    input  logic                            miso,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_mosi,
    output logic [DATA_W-1:0]               out_miso,
    output logic [$clog2(DATA_W+1)-1:0]     out_bits,
    output logic                            out_sof,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overflow,
    input  logic                            clear_overflow
);
    localparam int unsigned BITS_W = $clog2(DATA_W + 1);
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic {StIdle, StActive} state_e;

    logic sck_s1, sck_s2, sck_s3;
    logic cs_s1, cs_s2, cs_s3;
    logic mosi_s1, mosi_s2, miso_s1, miso_s2;
    logic vld_s1, vld_s2, armed_q;

    state_e state_q, state_d;
    logic   start_frame, end_frame, do_sample;
    logic   cs_fall, cs_rise, sck_rise, sck_fall, sample_edge;

    logic              cpol_q, cpha_q, sof_q;
    logic [BITS_W-1:0] cnt_q;
    logic [DATA_W-1:0] sr_mosi_q, sr_miso_q, mosi_shift, miso_shift;
    logic              word_done;

    logic              cap_valid_q, cap_sof_q;
    logic [DATA_W-1:0] cap_mosi_q, cap_miso_q;
    logic [BITS_W-1:0] cap_bits_q;
    logic              push_valid_q, push_sof_q;
    logic [DATA_W-1:0] push_mosi_q, push_miso_q;
    logic [BITS_W-1:0] push_bits_q;

    logic [DATA_W-1:0] mem_mosi [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_miso [FIFO_DEPTH];
    logic [BITS_W-1:0] mem_bits [FIFO_DEPTH];
    logic              mem_sof  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              overflow_q, full, pop, wr_en, drop;

    // vld_s* marks when cs_s2 holds a real sample; a frame may only start after cs_n was seen
    // high, so a cs_n already low when reset releases never opens a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
            vld_s1  <= 1'b0;
            vld_s2  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
            vld_s1  <= 1'b1;
            vld_s2  <= vld_s1;
            armed_q <= armed_q | (vld_s2 & cs_s2);
        end
    end

    assign cs_fall     = armed_q & cs_s3 & ~cs_s2;
    assign cs_rise     = ~cs_s3 & cs_s2;
    assign sck_rise    = sck_s2 & ~sck_s3;
    assign sck_fall    = ~sck_s2 & sck_s3;
    // Modes 1 and 2 sample on the falling edge, modes 0 and 3 on the rising edge.
    assign sample_edge = (cpol_q ^ cpha_q) ? sck_fall : sck_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cs_fall) state_d = StActive;
            StActive: if (cs_rise) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        start_frame = (state_q == StIdle) && cs_fall;
        end_frame   = (state_q == StActive) && cs_rise;
        do_sample   = (state_q == StActive) && sample_edge && !cs_rise;
    end

    always_comb begin
        if (MSB_FIRST != 0) begin
            mosi_shift = {sr_mosi_q[DATA_W-2:0], mosi_s2};
            miso_shift = {sr_miso_q[DATA_W-2:0], miso_s2};
        end else begin
            mosi_shift = {mosi_s2, sr_mosi_q[DATA_W-1:1]};
            miso_shift = {miso_s2, sr_miso_q[DATA_W-1:1]};
        end
    end

    assign word_done = (cnt_q == BITS_W'(DATA_W - 1));

`ifdef SPI_FRAME_MONITOR_PARTIAL_EN
    logic [BITS_W-1:0] shamt;
    logic [DATA_W-1:0] mosi_part, miso_part;

    // MSB-first bits already sit right-aligned; LSB-first bits must slide down to bit 0.
    always_comb begin
        shamt = BITS_W'(DATA_W) - cnt_q;
        if (MSB_FIRST != 0) begin
            mosi_part = sr_mosi_q;
            miso_part = sr_miso_q;
        end else begin
            mosi_part = sr_mosi_q >> shamt;
            miso_part = sr_miso_q >> shamt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            sof_q       <= 1'b0;
            cnt_q       <= '0;
            sr_mosi_q   <= '0;
            sr_miso_q   <= '0;
            cap_valid_q <= 1'b0;
            cap_sof_q   <= 1'b0;
            cap_mosi_q  <= '0;
            cap_miso_q  <= '0;
            cap_bits_q  <= '0;
        end else begin
            cap_valid_q <= 1'b0;
            if (start_frame) begin
                cpol_q    <= cpol;
                cpha_q    <= cpha;
                sof_q     <= 1'b1;
                cnt_q     <= '0;
                sr_mosi_q <= '0;
                sr_miso_q <= '0;
            end else if (do_sample) begin
                if (word_done) begin
                    cap_valid_q <= 1'b1;
                    cap_mosi_q  <= mosi_shift;
                    cap_miso_q  <= miso_shift;
                    cap_bits_q  <= BITS_W'(DATA_W);
                    cap_sof_q   <= sof_q;
                    sof_q       <= 1'b0;
                    cnt_q       <= '0;
                    sr_mosi_q   <= '0;
                    sr_miso_q   <= '0;
                end else begin
                    cnt_q     <= cnt_q + BITS_W'(1);
                    sr_mosi_q <= mosi_shift;
                    sr_miso_q <= miso_shift;
                end
            end else if (end_frame) begin
`ifdef SPI_FRAME_MONITOR_PARTIAL_EN
                if (cnt_q != '0) begin
                    cap_valid_q <= 1'b1;
                    cap_mosi_q  <= mosi_part;
                    cap_miso_q  <= miso_part;
                    cap_bits_q  <= cnt_q;
                    cap_sof_q   <= sof_q;
                end
`endif
                cnt_q     <= '0;
                sr_mosi_q <= '0;
                sr_miso_q <= '0;
            end
        end
    end

    // Extra stage so a completed word reaches the FIFO a fixed 4 cycles after sync capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_valid_q <= 1'b0;
            push_sof_q   <= 1'b0;
            push_mosi_q  <= '0;
            push_miso_q  <= '0;
            push_bits_q  <= '0;
        end else begin
            push_valid_q <= cap_valid_q;
            push_sof_q   <= cap_sof_q;
            push_mosi_q  <= cap_mosi_q;
            push_miso_q  <= cap_miso_q;
            push_bits_q  <= cap_bits_q;
        end
    end

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop   = out_valid & out_ready;
    assign wr_en = push_valid_q & (~full | pop);
    assign drop  = push_valid_q & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_mosi[wr_ptr_q] <= push_mosi_q;
            mem_miso[wr_ptr_q] <= push_miso_q;
            mem_bits[wr_ptr_q] <= push_bits_q;
            mem_sof[wr_ptr_q]  <= push_sof_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(wr_en) - LVL_W'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        out_valid  = (level_q != '0);
        out_mosi   = out_valid ? mem_mosi[rd_ptr_q] : '0;
        out_miso   = out_valid ? mem_miso[rd_ptr_q] : '0;
        out_bits   = out_valid ? mem_bits[rd_ptr_q] : '0;
        out_sof    = out_valid ? mem_sof[rd_ptr_q] : 1'b0;
        fifo_level = level_q;
        overflow   = overflow_q;
    end

endmodule
